alu_op_sequencer: RTL

Sequencing and arbitration controller for the shared 4-bit ALU datapath (A[3:0], B[3:0], M[2:0] → F[7:0]).
- Two independent requesters submit operations over valid/ready handshakes; a round-robin arbiter picks one.
- The controller drives the ALU operand and mode lines from registers and captures the combinational result one cycle later.
- It returns the result tagged with the requester id over a valid/ready response channel.
- It sits between the control logic (keypad/switch front-ends, test drivers) and the ALU instance, which stays purely combinational.

---
 rtl/alu_seq_pkg.sv | 17 +
 rtl/alu_op_sequencer_rr_arbiter2.sv | 14 +
 rtl/alu_op_sequencer.sv | 81 ++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types, widths and ALU mode encodings for the ALU op sequencer
package alu_seq_pkg;
    localparam int OPW  = 4;
    localparam int RESW = 8;
    localparam int MW   = 3;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [MW-1:0] ALU_ADD  = 3'd0;
    localparam logic [MW-1:0] ALU_SUB  = 3'd1;
    localparam logic [MW-1:0] ALU_INC  = 3'd2;
    localparam logic [MW-1:0] ALU_DEC  = 3'd3;
    localparam logic [MW-1:0] ALU_MUL2 = 3'd4;
    localparam logic [MW-1:0] ALU_DIV2 = 3'd5;
    localparam logic [MW-1:0] ALU_AND  = 3'd6;
    localparam logic [MW-1:0] ALU_OR   = 3'd7;
endpackage

// File: rtl/alu_op_sequencer_rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant; the last-served pointer lives outside
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       enable,
    output logic [1:0] gnt,
    output logic       gnt_id
);
    // on a tie the requester not served last wins; otherwise the lone requester wins
    always_comb begin
        gnt_id = (req == 2'b11) ? ~last : (req[1] & ~req[0]);
        gnt    = (enable && req != 2'b00) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: arbitrates two requesters onto a shared combinational ALU and returns tagged results
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [2*OPW-1:0]  req_a,
    input  logic [2*OPW-1:0]  req_b,
    input  logic [2*MW-1:0]   req_m,
    output logic [OPW-1:0]    alu_a,
    output logic [OPW-1:0]    alu_b,
    output logic [MW-1:0]     alu_m,
    input  logic [RESW-1:0]   alu_f,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [RESW-1:0]   resp_data,
    output logic              resp_id,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count
);
    state_t state, next;
    logic   last;
    logic   gnt_id;
    logic   hs;

    rr_arbiter2 u_arb (
        .req    (req_valid),
        .last   (last),
        .enable (state == IDLE),
        .gnt    (req_ready),
        .gnt_id (gnt_id)
    );

    assign hs = |req_ready;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // next state and status outputs
    always_comb begin
        next       = state;
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
        case (state)
            IDLE:    next = hs ? EXEC : IDLE;
            EXEC:    next = RESP;
            RESP:    next = resp_ready ? IDLE : RESP;
            default: next = IDLE;
        endcase
    end

    // operand capture on grant, result capture after EXEC, completion counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_m     <= '0;
            resp_data <= '0;
            resp_id   <= 1'b0;
            last      <= 1'b1;
            op_count  <= '0;
        end else begin
            if (state == IDLE && hs) begin
                alu_a   <= gnt_id ? req_a[2*OPW-1:OPW] : req_a[OPW-1:0];
                alu_b   <= gnt_id ? req_b[2*OPW-1:OPW] : req_b[OPW-1:0];
                alu_m   <= gnt_id ? req_m[2*MW-1:MW]   : req_m[MW-1:0];
                resp_id <= gnt_id;
                last    <= gnt_id;
            end
            if (state == EXEC) resp_data <= alu_f;
            if (state == RESP && resp_ready) op_count <= op_count + CNT_W'(1);
        end
    end
endmodule
